// File: rtl/sram_bist_pkg.sv
// rtl/sram_bist_pkg.sv - shared types, constants and March C- element table for the SRAM BIST
package sram_bist_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int WMASK_W = DATA_W / 8;
    localparam int DEPTH   = 256;

    localparam logic [DATA_W-1:0] BG0 = 32'h0000_0000;
    localparam logic [DATA_W-1:0] BG1 = 32'h5555_5555;

    typedef enum logic [3:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
    } state_t;

    typedef logic [2:0] elem_t;

    localparam elem_t LAST_ELEM = 3'd5;

    // rd_inv/wr_inv select the complement of the background for that operation
    typedef struct packed {
        logic down;
        logic rd_en;
        logic rd_inv;
        logic wr_en;
        logic wr_inv;
    } elem_cfg_t;

    function automatic elem_cfg_t elem_cfg(input elem_t e);
        elem_cfg_t c;
        case (e)
            3'd0:    c = '{down: 1'b0, rd_en: 1'b0, rd_inv: 1'b0, wr_en: 1'b1, wr_inv: 1'b0};
            3'd1:    c = '{down: 1'b0, rd_en: 1'b1, rd_inv: 1'b0, wr_en: 1'b1, wr_inv: 1'b1};
            3'd2:    c = '{down: 1'b0, rd_en: 1'b1, rd_inv: 1'b1, wr_en: 1'b1, wr_inv: 1'b0};
            3'd3:    c = '{down: 1'b1, rd_en: 1'b1, rd_inv: 1'b0, wr_en: 1'b1, wr_inv: 1'b1};
            3'd4:    c = '{down: 1'b1, rd_en: 1'b1, rd_inv: 1'b1, wr_en: 1'b1, wr_inv: 1'b0};
            3'd5:    c = '{down: 1'b0, rd_en: 1'b1, rd_inv: 1'b0, wr_en: 1'b0, wr_inv: 1'b0};
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic elem_down(input elem_t e);
        elem_cfg_t c;
        c = elem_cfg(e);
        return c.down;
    endfunction

    function automatic elem_t state_elem(input state_t s);
        return 3'(4'(s) - 4'd1);
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// rtl/sram_bist_addr_gen.sv - loadable up/down march address counter with terminal-count flag
module sram_bist_addr_gen
    import sram_bist_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              en_i,
    input  logic              down_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              tc_o
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (en_i) begin
            addr_d = down_i ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign tc_o   = down_i ? (addr_q == '0) : (addr_q == ADDR_MAX);

endmodule

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - March C- BIST controller for a 1RW1R SRAM macro
// Optional second background pass enabled by defining SRAM_BIST_BG_EN.
module sram_bist_ctrl
    import sram_bist_pkg::*;
(
    input  logic               clk0,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2:0]         fail_elem,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [DATA_W-1:0]  fail_data,
    output logic               csb0,
    output logic               web0,
    output logic [WMASK_W-1:0] wmask0,
    output logic [ADDR_W-1:0]  addr0,
    output logic [DATA_W-1:0]  din0,
    output logic               csb1,
    output logic [ADDR_W-1:0]  addr1,
    input  logic [DATA_W-1:0]  dout1
);

    state_t            state_q, state_d;
    logic              ph_q, ph_d;
    logic              bg_q, bg_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              pass_q, pass_d;
    elem_t             fail_elem_q, fail_elem_d;
    logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
    logic [DATA_W-1:0] fail_data_q, fail_data_d;

    logic              ld, adv, tc;
    logic [ADDR_W-1:0] ld_val, addr;
    elem_t             elem, cmp_elem;
    elem_cfg_t         cfg;
    logic              in_elem, two_op, cmp_en, mismatch;
    logic [DATA_W-1:0] bg, cmp_exp;
    logic [ADDR_W-1:0] cmp_addr;

    assign elem    = state_elem(state_q);
    assign cfg     = elem_cfg(elem);
    assign in_elem = (state_q >= S_M0) && (state_q <= S_M5);
    assign two_op  = cfg.rd_en && cfg.wr_en;
    assign bg      = bg_q ? BG1 : BG0;

    sram_bist_addr_gen u_addr_gen (
        .clk_i      (clk0),
        .rst_n_i    (rst_n),
        .load_i     (ld),
        .load_val_i (ld_val),
        .en_i       (adv),
        .down_i     (cfg.down),
        .addr_o     (addr),
        .tc_o       (tc)
    );

    // Two-op elements check their read in the following write cycle; M5 reads
    // are checked one cycle late, the last one in DRAIN (whose cfg is all-zero).
    always_comb begin
        cmp_en   = 1'b0;
        cmp_exp  = cfg.rd_inv ? ~bg : bg;
        cmp_addr = addr;
        cmp_elem = elem;
        if (in_elem && two_op && ph_q) begin
            cmp_en = 1'b1;
        end else if ((state_q == S_M5 || state_q == S_DRAIN) && rd_pend_q) begin
            cmp_en   = 1'b1;
            cmp_addr = rd_addr_q;
            cmp_elem = LAST_ELEM;
        end
    end

    assign mismatch = cmp_en && (dout1 != cmp_exp);

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ph_q        <= 1'b0;
            bg_q        <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
            pass_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            bg_q        <= bg_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
            pass_q      <= pass_d;
            fail_elem_q <= fail_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ph_d        = ph_q;
        bg_d        = bg_q;
        rd_pend_d   = (state_q == S_M5);
        rd_addr_d   = addr;
        pass_d      = pass_q;
        fail_elem_d = fail_elem_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        ld          = 1'b0;
        ld_val      = '0;
        adv         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_M0;
                    ld          = 1'b1;
                    ph_d        = 1'b0;
                    bg_d        = 1'b0;
                    pass_d      = 1'b0;
                    fail_elem_d = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
                if (two_op) ph_d = ~ph_q;
                if (!two_op || ph_q) begin
                    if (tc) begin
                        state_d = state_t'(state_q + 4'd1);
                        ld      = 1'b1;
                        ld_val  = {ADDR_W{elem_down(elem + 3'd1)}};
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
`ifdef SRAM_BIST_BG_EN
                if (!bg_q) begin
                    state_d = S_M0;
                    ld      = 1'b1;
                    bg_d    = 1'b1;
                end else
`endif
                begin
                    state_d = S_DONE;
                    pass_d  = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (mismatch) begin
            state_d     = S_DONE;
            pass_d      = 1'b0;
            fail_elem_d = cmp_elem;
            fail_addr_d = cmp_addr;
            fail_data_d = dout1;
            ld          = 1'b0;
            adv         = 1'b0;
        end
    end

    always_comb begin
        busy   = (state_q != S_IDLE) && (state_q != S_DONE);
        done   = (state_q == S_DONE);
        csb0   = 1'b1;
        web0   = 1'b1;
        wmask0 = '0;
        addr0  = '0;
        din0   = '0;
        csb1   = 1'b1;
        addr1  = '0;
        if (in_elem) begin
            if (cfg.wr_en && (!cfg.rd_en || ph_q)) begin
                csb0   = 1'b0;
                web0   = 1'b0;
                wmask0 = '1;
                addr0  = addr;
                din0   = cfg.wr_inv ? ~bg : bg;
            end
            if (cfg.rd_en && (!cfg.wr_en || !ph_q)) begin
                csb1  = 1'b0;
                addr1 = addr;
            end
        end
    end

    assign pass      = pass_q;
    assign fail_elem = fail_elem_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - self-checking bench for sram_bist_ctrl with a fault-injecting SRAM model
module tb_sram_bist_ctrl;

`ifdef SRAM_BIST_BG_EN
    localparam int BUSY_FULL = 5122;
`else
    localparam int BUSY_FULL = 2561;
`endif

    logic        clk0 = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [2:0]  fail_elem;
    logic [7:0]  fail_addr;
    logic [31:0] fail_data;
    logic        csb0, web0, csb1;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0;
    logic [31:0] dout1 = '0;

    always #5 clk0 = ~clk0;

    sram_bist_ctrl dut (
        .clk0(clk0), .rst_n(rst_n), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_elem(fail_elem), .fail_addr(fail_addr), .fail_data(fail_data),
        .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1)
    );

    // fault_mode: 0 none, 1 read of 0x3C forces bit 5, 2 write 0x10 also hits 0x11, 3 bit 0 stuck-at-0 at 0x80
    int          fault_mode = 0;
    logic [31:0] mem [256];

    always @(posedge clk0) begin
        if (!csb1) dout1 <= (fault_mode == 1 && addr1 == 8'h3C) ? (mem[addr1] | 32'h20) : mem[addr1];
        if (!csb0 && !web0) begin
            mem[addr0] <= (fault_mode == 3 && addr0 == 8'h80) ? (din0 & ~32'h1) : din0;
            if (fault_mode == 2 && addr0 == 8'h10) mem[8'h11] <= din0;
        end
    end

    int busy_cnt = 0, done_cnt = 0, stray_cnt = 0, proto_cnt = 0;

    always @(negedge clk0) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (!busy && (!csb0 || !csb1)) stray_cnt++;
        if (!csb0 && (web0 || wmask0 != 4'hF)) proto_cnt++;
        if (csb0 && (!web0 || wmask0 != 4'h0 || addr0 != 8'h0 || din0 != 32'h0)) proto_cnt++;
        if (csb1 && addr1 != 8'h0) proto_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".status"}, 64'({busy, done, pass, fail_elem}), 64'(0));
        chk({tag, ".fail"}, 64'({fail_addr, fail_data}), 64'(0));
        chk({tag, ".ports"}, 64'({csb0, csb1, web0, wmask0, addr0, addr1, din0}), {9'b0, 3'b111, 52'h0});
    endtask

    task automatic do_run(input string tag, input int exp_busy, input logic exp_pass, input logic [2:0] exp_elem,
                          input logic [7:0] exp_addr, input logic [31:0] exp_data, input int retrig_at);
        int  b_busy, b_done, b_stray, b_proto;
        bit  got;
        b_busy = busy_cnt; b_done = done_cnt; b_stray = stray_cnt; b_proto = proto_cnt;
        got = 1'b0;
        @(negedge clk0) start = 1'b1;
        for (int n = 1; n <= 8000 && !got; n++) begin
            @(negedge clk0);
            start = (n == retrig_at);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk({tag, ".done_seen"}, 64'(got), 64'(1));
        chk({tag, ".pass"}, 64'(pass), 64'(exp_pass));
        chk({tag, ".fail_elem"}, 64'(fail_elem), 64'(exp_elem));
        chk({tag, ".fail_addr"}, 64'(fail_addr), 64'(exp_addr));
        chk({tag, ".fail_data"}, 64'(fail_data), 64'(exp_data));
        chk({tag, ".busy_at_done"}, 64'(busy), 64'(0));
        repeat (3) @(negedge clk0);
        chk({tag, ".busy_cycles"}, 64'(busy_cnt - b_busy), 64'(exp_busy));
        chk({tag, ".done_pulses"}, 64'(done_cnt - b_done), 64'(1));
        chk({tag, ".stray_access"}, 64'(stray_cnt - b_stray), 64'(0));
        chk({tag, ".port_protocol"}, 64'(proto_cnt - b_proto), 64'(0));
    endtask

    typedef struct {
        string       name;
        int          fault;
        int          exp_busy;
        logic        exp_pass;
        logic [2:0]  exp_elem;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vec [4];

    initial begin
        bit got;
        // busy lengths for failing runs: M0 256 + 2 cycles per address checked up to and including the failing one
        vec[0] = '{"clean",   0, BUSY_FULL, 1'b1, 3'd0, 8'h00, 32'h0000_0000};
        vec[1] = '{"rd_bit5", 1, 378,       1'b0, 3'd1, 8'h3C, 32'h0000_0020};
        vec[2] = '{"decoder", 2, 292,       1'b0, 3'd1, 8'h11, 32'hFFFF_FFFF};
        vec[3] = '{"stuck0",  3, 1026,      1'b0, 3'd2, 8'h80, 32'hFFFF_FFFE};

        repeat (3) @(negedge clk0);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk0);

        for (int i = 0; i < 4; i++) begin
            fault_mode = vec[i].fault;
            do_run(vec[i].name, vec[i].exp_busy, vec[i].exp_pass, vec[i].exp_elem, vec[i].exp_addr, vec[i].exp_data, 0);
        end
        fault_mode = 0;

        // reset in the middle of a run, then a clean run
        @(negedge clk0) start = 1'b1;
        @(negedge clk0) start = 1'b0;
        repeat (699) @(negedge clk0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk0) rst_n = 1'b1;
        @(negedge clk0);
        do_run("after_rst", BUSY_FULL, 1'b1, 3'd0, 8'h00, 32'h0, 0);

        // second start pulse mid-run must be ignored
        do_run("retrig", BUSY_FULL, 1'b1, 3'd0, 8'h00, 32'h0, 100);

        // start held high: one IDLE cycle after DONE, then the next run begins
        got = 1'b0;
        @(negedge clk0) start = 1'b1;
        for (int n = 0; n < 8000 && !got; n++) begin
            @(negedge clk0);
            if (done) got = 1'b1;
        end
        chk("b2b.first_done", 64'(got), 64'(1));
        chk("b2b.first_pass", 64'(pass), 64'(1));
        @(negedge clk0);
        chk("b2b.idle_gap", 64'({busy, done}), 64'(0));
        @(negedge clk0);
        chk("b2b.restart", 64'(busy), 64'(1));
        start = 1'b0;
        got = 1'b0;
        for (int n = 0; n < 8000 && !got; n++) begin
            @(negedge clk0);
            if (done) got = 1'b1;
        end
        chk("b2b.second_done", 64'(got), 64'(1));
        chk("b2b.second_pass", 64'(pass), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
